// File: rtl/game2048_pkg.sv
// Shared types and helpers for the 2048 game front end.
// Direction encoding doubles as the bit index of the one-hot move vector.
package game2048_pkg;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } move_dir_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    PULSE,
    WAIT_RELEASE
  } input_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Fixed priority up > down > left > right; lower-priority events are dropped.
  function automatic move_dir_t pick_dir(input logic [3:0] evt);
    if (evt[0])      return DIR_UP;
    else if (evt[1]) return DIR_DOWN;
    else if (evt[2]) return DIR_LEFT;
    else             return DIR_RIGHT;
  endfunction

  function automatic logic [3:0] dir_onehot(input move_dir_t dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Button/move bundle between the board, the input controller and the game FSM.
// master drives buttons and game_busy; slave is the controller.
interface move_input_ctrl_if;
  logic btn_up_n;
  logic btn_down_n;
  logic btn_left_n;
  logic btn_right_n;
  logic game_busy;
  logic move_up;
  logic move_down;
  logic move_left;
  logic move_right;
  logic move_pending;

  modport master (
    output btn_up_n, btn_down_n, btn_left_n, btn_right_n, game_busy,
    input  move_up, move_down, move_left, move_right, move_pending
  );

  modport slave (
    input  btn_up_n, btn_down_n, btn_left_n, btn_right_n, game_busy,
    output move_up, move_down, move_left, move_right, move_pending
  );
endinterface

// File: rtl/btn_debouncer.sv
// Synchronises one active-low pushbutton and debounces it into a clean
// pressed level plus a one-cycle press strobe.
module btn_debouncer
  import game2048_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic stable,
  output logic press_evt
);

  logic             sync1;
  logic             sync2;
  logic             stable_d;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic             pressed_sync;

  assign pressed_sync = ~sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes sync1 -> sync2 a real two-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn_n;
      sync2    <= sync1;
      stable_d <= stable;
      if (pressed_sync == stable) begin
        cnt <= '0;
        // A genuine released sample is needed before the first press may count.
        if (!stable) armed <= 1'b1;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        stable <= pressed_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Without the armed gate a key still held through reset would look like a
  // fresh press once the zeroed synchroniser settles.
  assign press_evt = stable & ~stable_d & armed;

endmodule

// File: rtl/move_input_ctrl.sv
// Turns four debounced pushbuttons into single one-hot move pulses for the
// 2048 game, waiting out game_busy and requiring a full release to rearm.
module move_input_ctrl
  import game2048_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20
) (
  input logic               clk,
  input logic               reset,
  move_input_ctrl_if.slave  bus
);

  logic [3:0]   btn_n;
  logic [3:0]   stable;
  logic [3:0]   press_evt;
  input_state_t state_q;
  input_state_t state_d;
  move_dir_t    dir_q;
  move_dir_t    dir_d;
  logic [3:0]   move_q;
  logic [3:0]   move_d;
  logic         pending_q;
  logic         pending_d;

  assign btn_n = {bus.btn_right_n, bus.btn_left_n, bus.btn_down_n, bus.btn_up_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .btn_n    (btn_n[i]),
      .stable   (stable[i]),
      .press_evt(press_evt[i])
    );
  end

  // State, captured direction and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      move_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      move_q    <= move_d;
      pending_q <= pending_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (|press_evt) begin
          dir_d   = pick_dir(press_evt);
          state_d = bus.game_busy ? WAIT_READY : PULSE;
        end
      end
      WAIT_READY:   if (!bus.game_busy) state_d = PULSE;
      PULSE:        state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (stable == 4'b0000) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    move_d    = '0;
    pending_d = (state_d == WAIT_READY);
    if (state_d == PULSE) move_d = dir_onehot(dir_d);
  end

  assign bus.move_up      = move_q[0];
  assign bus.move_down    = move_q[1];
  assign bus.move_left    = move_q[2];
  assign bus.move_right   = move_q[3];
  assign bus.move_pending = pending_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with DEBOUNCE_CYCLES=4: a press held
// from edge 0 must give a one-cycle move pulse from edge 7 to edge 8.
module tb_move_input_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int   up_cnt = 0;
  int   down_cnt = 0;
  int   left_cnt = 0;
  int   right_cnt = 0;
  int   pend_cnt = 0;
  int   multi_cnt = 0;

  int   b_up, b_down, b_left, b_right, b_pend;

  move_input_ctrl_if bus ();

  move_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // High-cycle counters sampled mid-cycle; a stretched pulse counts twice.
  always @(negedge clk) begin
    if (bus.move_up)      up_cnt++;
    if (bus.move_down)    down_cnt++;
    if (bus.move_left)    left_cnt++;
    if (bus.move_right)   right_cnt++;
    if (bus.move_pending) pend_cnt++;
    if ($countones({bus.move_up, bus.move_down, bus.move_left, bus.move_right}) > 1)
      multi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_up = up_cnt; b_down = down_cnt; b_left = left_cnt;
    b_right = right_cnt; b_pend = pend_cnt;
  endtask

  function automatic logic [3:0] moves();
    return {bus.move_right, bus.move_left, bus.move_down, bus.move_up};
  endfunction

  initial begin
    bus.btn_up_n    = 1'b1;
    bus.btn_down_n  = 1'b1;
    bus.btn_left_n  = 1'b1;
    bus.btn_right_n = 1'b1;
    bus.game_busy   = 1'b0;

    // Reset state
    tick(3);
    check("reset_moves", 32'(moves()), 0);
    check("reset_pending", 32'(bus.move_pending), 0);
    reset = 1'b0;
    tick(10);
    check("idle_moves", 32'(moves()), 0);

    // Clean press of up: pulse edge 7..8 only
    snap();
    bus.btn_up_n = 1'b0;
    tick(7);
    check("clean_edge6", 32'(moves()), 0);
    tick(1);
    check("clean_edge7", 32'(moves()), 32'h1);
    check("clean_pending", 32'(bus.move_pending), 0);
    tick(1);
    check("clean_edge8", 32'(moves()), 0);
    bus.btn_up_n = 1'b1;
    tick(12);
    check("clean_up_cycles", 32'(up_cnt - b_up), 1);
    check("clean_other_cycles", 32'((down_cnt - b_down) + (left_cnt - b_left) + (right_cnt - b_right)), 0);
    check("clean_pend_cycles", 32'(pend_cnt - b_pend), 0);

    // Bounce on left: 2-cycle low glitches never debounce
    snap();
    for (int i = 0; i < 5; i++) begin
      bus.btn_left_n = 1'b0;
      tick(2);
      bus.btn_left_n = 1'b1;
      tick(2);
    end
    tick(10);
    check("bounce_no_pulse", 32'(left_cnt - b_left), 0);
    bus.btn_left_n = 1'b0;
    tick(7);
    check("bounce_hold_edge6", 32'(moves()), 0);
    tick(1);
    check("bounce_hold_edge7", 32'(moves()), 32'h4);
    tick(1);
    check("bounce_hold_edge8", 32'(moves()), 0);
    bus.btn_left_n = 1'b1;
    tick(12);
    check("bounce_left_cycles", 32'(left_cnt - b_left), 1);

    // Busy hold on right
    snap();
    bus.game_busy   = 1'b1;
    bus.btn_right_n = 1'b0;
    tick(8);
    check("busy_pending_on", 32'(bus.move_pending), 1);
    check("busy_no_move", 32'(moves()), 0);
    tick(9);
    check("busy_pending_hold", 32'(bus.move_pending), 1);
    check("busy_no_pulse_yet", 32'(right_cnt - b_right), 0);
    bus.game_busy = 1'b0;
    tick(1);
    check("busy_release_pulse", 32'(moves()), 32'h8);
    check("busy_pulse_pending", 32'(bus.move_pending), 0);
    tick(1);
    check("busy_after_pulse", 32'(moves()), 0);
    check("busy_after_pending", 32'(bus.move_pending), 0);
    bus.btn_right_n = 1'b1;
    tick(12);
    check("busy_right_cycles", 32'(right_cnt - b_right), 1);

    // Simultaneous down+left: down wins; up while held is ignored
    snap();
    bus.btn_down_n = 1'b0;
    bus.btn_left_n = 1'b0;
    tick(8);
    check("simul_down_only", 32'(moves()), 32'h2);
    tick(5);
    bus.btn_up_n = 1'b0;
    tick(15);
    check("simul_up_ignored", 32'(up_cnt - b_up), 0);
    check("simul_down_cycles", 32'(down_cnt - b_down), 1);
    check("simul_left_cycles", 32'(left_cnt - b_left), 0);
    bus.btn_up_n   = 1'b1;
    bus.btn_down_n = 1'b1;
    bus.btn_left_n = 1'b1;
    tick(12);
    bus.btn_up_n = 1'b0;
    tick(8);
    check("simul_up_rearmed", 32'(moves()), 32'h1);
    bus.btn_up_n = 1'b1;
    tick(12);

    // No auto-repeat on a long hold
    snap();
    bus.btn_up_n = 1'b0;
    tick(1000);
    check("hold_single_pulse", 32'(up_cnt - b_up), 1);
    bus.btn_up_n = 1'b1;
    tick(12);
    bus.btn_up_n = 1'b0;
    tick(8);
    check("hold_second_pulse", 32'(moves()), 32'h1);
    bus.btn_up_n = 1'b1;
    tick(12);
    check("hold_total_cycles", 32'(up_cnt - b_up), 2);

    // Asynchronous reset while waiting for the game
    bus.game_busy   = 1'b1;
    bus.btn_right_n = 1'b0;
    tick(10);
    check("rst_pending_before", 32'(bus.move_pending), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_pending", 32'(bus.move_pending), 0);
    check("rst_async_moves", 32'(moves()), 0);
    tick(2);
    reset = 1'b0;
    bus.game_busy = 1'b0;
    snap();
    tick(20);
    check("rst_held_no_pulse", 32'(right_cnt - b_right), 0);
    check("rst_held_no_pending", 32'(pend_cnt - b_pend), 0);
    bus.btn_right_n = 1'b1;
    tick(12);
    bus.btn_right_n = 1'b0;
    tick(8);
    check("rst_repress_pulse", 32'(moves()), 32'h8);
    bus.btn_right_n = 1'b1;
    tick(12);

    check("never_multi_hot", 32'(multi_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
